// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory responder.
//   - dm_state_t and the IDLE/ACCESS/RESP state encodings
//   - clog2() helper used for index widths
//   - DM_IDX_W: memory index width for the default depth
package dm_pkg;

    typedef logic [1:0] dm_state_t;

    localparam dm_state_t IDLE   = 2'd0;
    localparam dm_state_t ACCESS = 2'd1;
    localparam dm_state_t RESP   = 2'd2;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned DM_MEM_DEPTH = 256;
    localparam int unsigned DM_IDX_W     = clog2(DM_MEM_DEPTH);

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
// Searches req_i starting at rr_ptr_i and wrapping at core_count.
//   req_i       : per-core request vector
//   rr_ptr_i    : index with highest priority this round
//   gnt_valid_o : any request present
//   gnt_idx_o   : index of the granted core
module rr_arbiter
    import dm_pkg::*;
#(
    parameter int unsigned core_count = 2,
    parameter int unsigned gnt_w      = 1
) (
    input  logic [core_count-1:0] req_i,
    input  logic [gnt_w-1:0]      rr_ptr_i,
    output logic                  gnt_valid_o,
    output logic [gnt_w-1:0]      gnt_idx_o
);

    int unsigned      cand;
    logic [gnt_w-1:0] cand_idx;

    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < core_count; k++) begin
            cand     = (32'(rr_ptr_i) + k) % core_count;
            cand_idx = gnt_w'(cand);
            if (!gnt_valid_o && req_i[cand_idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/dm_responder.sv
// dm_responder: memory-side responder shared by core_count cores.
// Round-robin arbitration in IDLE, one access per three cycles
// (IDLE -> ACCESS -> RESP), one-cycle per-core acknowledge.
//   clk, reset (async, active-low)
//   core_addr/core_wdata : per-core address / write data slices
//   core_write/core_read : per-core level requests, held until ack
//   DM_dataout           : per-core last read (or written) word
//   core_ack/core_err    : per-core completion pulse / error flag
//   busy                 : FSM not in IDLE
// Optional: define DM_RANGE_CHECK_EN to reject addresses with bits set at
// or above log2(mem_depth); otherwise the address wraps and core_err is 0.
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned reg_width  = 12,
    parameter int unsigned mem_depth  = 256,
    parameter int unsigned core_count = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [core_count*reg_width-1:0]  core_addr,
    input  logic [core_count*reg_width-1:0]  core_wdata,
    input  logic [core_count-1:0]            core_write,
    input  logic [core_count-1:0]            core_read,
    output logic [core_count*reg_width-1:0]  DM_dataout,
    output logic [core_count-1:0]            core_ack,
    output logic [core_count-1:0]            core_err,
    output logic                             busy
);

    localparam int unsigned IdxW = clog2(mem_depth);
    localparam int unsigned GntW = (core_count > 1) ? clog2(core_count) : 1;

    dm_state_t                      state_q, state_d;
    logic [GntW-1:0]                rr_ptr_q, rr_ptr_d;
    logic [GntW-1:0]                gnt_q, gnt_d;
    logic [reg_width-1:0]           addr_q, addr_d;
    logic [reg_width-1:0]           wdata_q, wdata_d;
    logic                           wr_q, wr_d;
    logic [core_count*reg_width-1:0] dout_q, dout_d;

    logic [reg_width-1:0] mem_q [mem_depth];

    logic [core_count-1:0] req;
    logic                  gnt_valid;
    logic [GntW-1:0]       gnt_idx;
    logic [IdxW-1:0]       idx;
    logic                  oor;
    logic                  mem_we;
    logic [reg_width-1:0]  resp_word;

    assign req = core_read | core_write;
    assign idx = addr_q[IdxW-1:0];

    rr_arbiter #(
        .core_count (core_count),
        .gnt_w      (GntW)
    ) u_rr_arbiter (
        .req_i       (req),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

`ifdef DM_RANGE_CHECK_EN
    logic err_q, err_d;
    assign oor = |(addr_q >> IdxW);
`else
    logic unused_addr_hi;
    assign oor            = 1'b0;
    assign unused_addr_hi = ^addr_q;
`endif

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_d     = gnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        dout_d    = dout_q;
        mem_we    = 1'b0;
        resp_word = '0;
`ifdef DM_RANGE_CHECK_EN
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d  = ACCESS;
                    gnt_d    = gnt_idx;
                    rr_ptr_d = (32'(gnt_idx) == core_count - 1) ? '0 : gnt_idx + 1'b1;
                    addr_d   = core_addr[gnt_idx*reg_width +: reg_width];
                    wdata_d  = core_wdata[gnt_idx*reg_width +: reg_width];
                    // Read+write together is a write returning the new word.
                    wr_d     = core_write[gnt_idx];
                end
            end
            ACCESS: begin
                state_d = RESP;
                mem_we  = wr_q & ~oor;
                if (!oor) begin
                    resp_word = wr_q ? wdata_q : mem_q[idx];
                end
                dout_d[gnt_q*reg_width +: reg_width] = resp_word;
`ifdef DM_RANGE_CHECK_EN
                err_d = oor;
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            dout_q   <= '0;
`ifdef DM_RANGE_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            dout_q   <= dout_d;
`ifdef DM_RANGE_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    // Storage is never cleared; a reset during ACCESS forces state_q to IDLE,
    // which drops mem_we before the next edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wdata_q;
        end
    end

    always_comb begin
        core_ack = '0;
        core_err = '0;
        if (state_q == RESP) begin
            core_ack[gnt_q] = 1'b1;
`ifdef DM_RANGE_CHECK_EN
            core_err[gnt_q] = err_q;
`endif
        end
    end

    assign DM_dataout = dout_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed self-checking bench for dm_responder
// (reg_width=12, mem_depth=256, core_count=2). Honours DM_RANGE_CHECK_EN.
module tb_dm_responder;

    localparam int RW = 12;
    localparam int CC = 2;

    logic              clk;
    logic              reset;
    logic [CC*RW-1:0]  core_addr;
    logic [CC*RW-1:0]  core_wdata;
    logic [CC-1:0]     core_write;
    logic [CC-1:0]     core_read;
    logic [CC*RW-1:0]  DM_dataout;
    logic [CC-1:0]     core_ack;
    logic [CC-1:0]     core_err;
    logic              busy;

    int n_checks;
    int n_errors;
    int lat;

    dm_responder #(
        .reg_width  (RW),
        .mem_depth  (256),
        .core_count (CC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_write (core_write),
        .core_read  (core_read),
        .DM_dataout (DM_dataout),
        .core_ack   (core_ack),
        .core_err   (core_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] dout(input int c);
        return DM_dataout[c*RW +: RW];
    endfunction

    // Drive a request on core c and wait (bounded) for its ack.
    task automatic run(input int c, input bit rd, input bit wr,
                       input logic [RW-1:0] a, input logic [RW-1:0] d, output int l);
        core_addr[c*RW +: RW]  = a;
        core_wdata[c*RW +: RW] = d;
        core_read[c]           = rd;
        core_write[c]          = wr;
        l = 0;
        do begin
            tick();
            l++;
        end while (core_ack[c] !== 1'b1 && l < 12);
    endtask

    // Drop core c's request and step out of RESP into IDLE.
    task automatic release_req(input int c);
        core_read[c]  = 1'b0;
        core_write[c] = 1'b0;
        tick();
    endtask

    logic [1:0] exp_ack3 [11];
    logic       exp_busy3 [11];
    logic [1:0] exp_ack7 [8];
    logic       exp_busy7 [8];

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        core_write = '0;
        core_read  = '0;

        exp_ack3  = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                      2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
        exp_busy3 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                      1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_ack7  = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
        exp_busy7 = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset held with a write pending: outputs stay quiet.
        core_write[0]        = 1'b1;
        core_addr[0 +: RW]   = 12'h005;
        core_wdata[0 +: RW]  = 12'hABC;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("reset_quiet", {DM_dataout, core_ack, core_err, busy}, '0);
        end
        reset = 1'b1;
        run(0, 1'b0, 1'b1, 12'h005, 12'hABC, lat);
        check_eq("wr_after_reset_lat", 64'(lat), 64'd2);
        check_eq("wr_after_reset_err", core_err, 2'b00);
        release_req(0);

        run(0, 1'b1, 1'b0, 12'h005, 12'h000, lat);
        check_eq("rd5_lat", 64'(lat), 64'd2);
        check_eq("rd5_data", dout(0), 12'hABC);
        release_req(0);

        // Both cores read continuously from a fresh rr_ptr.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        core_addr  = {12'h005, 12'h005};
        core_read  = 2'b11;
        for (int i = 0; i < 11; i++) begin
            tick();
            check_eq($sformatf("rr_ack_c%0d", i + 1), core_ack, exp_ack3[i]);
            check_eq($sformatf("rr_busy_c%0d", i + 1), busy, exp_busy3[i]);
        end
        check_eq("rr_c0_data", dout(0), 12'hABC);
        check_eq("rr_c1_data", dout(1), 12'hABC);
        core_read = 2'b00;
        tick();

        // Read+write together on core1 is a write returning the new word.
        run(1, 1'b1, 1'b1, 12'h010, 12'h123, lat);
        check_eq("rw_lat", 64'(lat), 64'd2);
        check_eq("rw_data", dout(1), 12'h123);
        release_req(1);
        check_eq("rw_ack_one_cycle", core_ack, 2'b00);
        run(0, 1'b1, 1'b0, 12'h010, 12'h000, lat);
        check_eq("rw_mem10", dout(0), 12'h123);
        release_req(0);

        // Upper address bits.
        run(0, 1'b0, 1'b1, 12'h105, 12'h456, lat);
        check_eq("hi_wr_lat", 64'(lat), 64'd2);
`ifdef DM_RANGE_CHECK_EN
        check_eq("hi_wr_err", core_err, 2'b01);
        release_req(0);
        run(0, 1'b1, 1'b0, 12'h105, 12'h000, lat);
        check_eq("hi_rd_data", dout(0), 12'h000);
        check_eq("hi_rd_err", core_err, 2'b01);
        release_req(0);
        run(0, 1'b1, 1'b0, 12'h005, 12'h000, lat);
        check_eq("hi_mem5_kept", dout(0), 12'hABC);
`else
        check_eq("hi_wr_err", core_err, 2'b00);
        release_req(0);
        run(0, 1'b1, 1'b0, 12'h005, 12'h000, lat);
        check_eq("hi_mem5_wrapped", dout(0), 12'h456);
`endif
        release_req(0);

        // Reset during ACCESS abandons the write.
        run(0, 1'b0, 1'b1, 12'h020, 12'h111, lat);
        release_req(0);
        core_addr[0 +: RW]  = 12'h020;
        core_wdata[0 +: RW] = 12'h777;
        core_write[0]       = 1'b1;
        tick();
        check_eq("abort_in_access", busy, 1'b1);
        reset = 1'b0;
        #1;
        check_eq("abort_busy", busy, 1'b0);
        core_write[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("abort_no_ack", core_ack, 2'b00);
        end
        reset = 1'b1;
        tick();
        check_eq("abort_idle", busy, 1'b0);
        check_eq("abort_idle_ack", core_ack, 2'b00);
        run(0, 1'b1, 1'b0, 12'h020, 12'h000, lat);
        check_eq("abort_mem20", dout(0), 12'h111);
        release_req(0);

        // core0 streams reads alone.
        core_addr[0 +: RW] = 12'h020;
        core_read[0]       = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("stream_ack_c%0d", i + 1), core_ack, exp_ack7[i]);
            check_eq($sformatf("stream_busy_c%0d", i + 1), busy, exp_busy7[i]);
        end
        check_eq("stream_data", dout(0), 12'h111);
        core_read[0] = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
